// File: rtl/data_sram_bridge.sv
// rtl/data_sram_bridge.sv - CPU data-port to req/addr_ok/data_ok memory bus bridge
// One access outstanding; cpu_stall held until the bus completes or the timeout fires.
module data_sram_bridge #(
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned CNT_W     = 8,
    parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cpu_en,
    input  logic [3:0]  cpu_wen,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic [31:0] mem_rdata,
    input  logic        mem_data_ok,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [31:2]       addr_q;
    logic [3:0]        wstrb_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic              is_wr;
    logic              timeout;
    logic              unused_addr_bits;

    // Bus is word addressed; the byte offset is carried by the strobes.
    assign unused_addr_bits = ^cpu_addr[1:0];

    assign is_wr   = |wstrb_q;
    assign cnt_d   = cnt_q + CNT_W'(1);
    assign timeout = (cnt_d == CNT_MAX);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wstrb_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu_en) begin
                        addr_q  <= cpu_addr[31:2];
                        wstrb_q <= cpu_wen;
                        wdata_q <= cpu_wdata;
                        cnt_q   <= '0;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    cnt_q <= cnt_d;
                    // A bus completion in the same cycle as the timeout wins.
                    if (mem_addr_ok && mem_data_ok) begin
                        if (!is_wr) rdata_q <= mem_rdata;
                        state_q <= DONE;
                    end else if (timeout) begin
                        err_q <= 1'b1;
                        if (!is_wr) rdata_q <= ERR_RDATA;
                        state_q <= DONE;
                    end else if (mem_addr_ok) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_d;
                    if (mem_data_ok) begin
                        if (!is_wr) rdata_q <= mem_rdata;
                        state_q <= DONE;
                    end else if (timeout) begin
                        err_q <= 1'b1;
                        if (!is_wr) rdata_q <= ERR_RDATA;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cpu_stall = (state_q == REQ) || (state_q == WAIT) || ((state_q == IDLE) && cpu_en);
    assign cpu_rdata = rdata_q;
    assign mem_req   = (state_q == REQ);
    assign mem_wr    = is_wr;
    assign mem_wstrb = wstrb_q;
    assign mem_addr  = {addr_q, 2'b00};
    assign mem_wdata = wdata_q;
    assign err       = err_q;

endmodule
